// File: rtl/id_fwd_stage.sv
// id_fwd_stage: RV32I decode and operand fetch with prioritised forwarding into a registered ID/EX slot.
// Latency: 1 cycle from accept (in_valid && in_ready) to out_valid.
// Backpressure: the slot holds while out_valid && !out_ready; a load-use hazard inserts a bubble and holds IF/ID.
module id_fwd_stage #(
  parameter int XLEN        = 32,
  parameter int RA_W        = 5,
  parameter int FWD_CH      = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [31:0]              inst_i,
  output logic [RA_W-1:0]          rs1,
  output logic [RA_W-1:0]          rs2,
  input  logic [XLEN-1:0]          r1_data,
  input  logic [XLEN-1:0]          r2_data,
  input  logic [FWD_CH-1:0]        fwd_valid,
  input  logic [FWD_CH-1:0]        fwd_pending,
  input  logic [FWD_CH*RA_W-1:0]   fwd_rd,
  input  logic [FWD_CH*XLEN-1:0]   fwd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          pc_o,
  output logic [10:0]              opt_o,
  output logic [XLEN-1:0]          vs1_o,
  output logic [XLEN-1:0]          vs2_o,
  output logic [XLEN-1:0]          imm_o,
  output logic [RA_W-1:0]          rd_o,
  output logic                     wen_o,
  output logic [STALL_CNT_W-1:0]   stall_cnt
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [6:0]      w_opc;
  logic [RA_W-1:0] w_rd;
  logic            w_legal;
  logic            w_use1;
  logic            w_use2;
  logic            w_wr;
  logic            w_wen;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic [10:0]     w_opt;
  logic [XLEN-1:0] w_fwd1;
  logic [XLEN-1:0] w_fwd2;
  logic            w_pend1;
  logic            w_pend2;
  logic [XLEN-1:0] w_vs1;
  logic [XLEN-1:0] w_vs2;
  logic            w_hazard;
  logic            w_slot_free;
  logic            w_take;

  // Returns {hazard, value}. Channels are scanned oldest-first so the youngest match is written last
  // and wins, including when it is still pending. x0 is hardwired and never forwarded.
  function automatic logic [XLEN:0] f_resolve(
    input logic [RA_W-1:0]        a,
    input logic [XLEN-1:0]        rf,
    input logic [FWD_CH-1:0]      fv,
    input logic [FWD_CH-1:0]      fp,
    input logic [FWD_CH*RA_W-1:0] frd,
    input logic [FWD_CH*XLEN-1:0] fd
  );
    logic [XLEN:0] res;
    res = {1'b0, rf};
    for (int c = FWD_CH - 1; c >= 0; c--) begin
      if (fv[c] && (frd[c*RA_W +: RA_W] == a)) begin
        res = {fp[c], fd[c*XLEN +: XLEN]};
      end
    end
    if (a == '0) begin
      res = '0;
    end
    return res;
  endfunction

  assign w_opc = inst_i[6:0];
  assign rs1   = inst_i[15 +: RA_W];
  assign rs2   = inst_i[20 +: RA_W];
  assign w_rd  = inst_i[7 +: RA_W];

  // Opcode decode: which sources are read, whether rd is written, and the immediate format.
  always_comb begin
    w_legal = 1'b1;
    w_use1  = 1'b0;
    w_use2  = 1'b0;
    w_wr    = 1'b0;
    w_imm32 = '0;
    case (w_opc)
      OPC_LUI, OPC_AUIPC: begin
        w_wr    = 1'b1;
        w_imm32 = {inst_i[31:12], 12'b0};
      end
      OPC_JAL: begin
        w_wr    = 1'b1;
        w_imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        w_use1  = 1'b1;
        w_wr    = 1'b1;
        w_imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      end
      OPC_BRANCH: begin
        w_use1  = 1'b1;
        w_use2  = 1'b1;
        w_imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      end
      OPC_STORE: begin
        w_use1  = 1'b1;
        w_use2  = 1'b1;
        w_imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      end
      OPC_OP: begin
        w_use1 = 1'b1;
        w_use2 = 1'b1;
        w_wr   = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_imm = XLEN'($signed(w_imm32));
  assign w_opt = w_legal ? {inst_i[30], inst_i[14:12], w_opc} : 11'd0;
  assign w_wen = w_wr && (w_rd != '0);

  assign {w_pend1, w_fwd1} = f_resolve(rs1, r1_data, fwd_valid, fwd_pending, fwd_rd, fwd_data);
  assign {w_pend2, w_fwd2} = f_resolve(rs2, r2_data, fwd_valid, fwd_pending, fwd_rd, fwd_data);

  // Unused sources read as 0 and cannot raise a hazard.
  assign w_vs1    = w_use1 ? w_fwd1 : '0;
  assign w_vs2    = w_use2 ? w_fwd2 : '0;
  assign w_hazard = in_valid && ((w_use1 && w_pend1) || (w_use2 && w_pend2));

  assign w_slot_free = !out_valid || out_ready;
  assign in_ready    = rst_n && rdy && !flush && w_slot_free && !w_hazard;
  assign w_take      = in_valid && in_ready;

  // ID/EX slot: reload when freed or flushed (bubble unless an instruction is taken), else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      pc_o      <= '0;
      opt_o     <= '0;
      vs1_o     <= '0;
      vs2_o     <= '0;
      imm_o     <= '0;
      rd_o      <= '0;
      wen_o     <= 1'b0;
    end else if (rdy && (flush || w_slot_free)) begin
      out_valid <= w_take;
      pc_o      <= w_take ? pc_i  : '0;
      opt_o     <= w_take ? w_opt : '0;
      vs1_o     <= w_take ? w_vs1 : '0;
      vs2_o     <= w_take ? w_vs2 : '0;
      imm_o     <= w_take ? w_imm : '0;
      rd_o      <= (w_take && w_wen) ? w_rd : '0;
      wen_o     <= w_take && w_wen;
    end
  end

  // Saturating count of cycles lost to a load-use hazard while the slot could have advanced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (rdy && !flush && w_slot_free && w_hazard && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule
